// File: rtl/lvds_ber_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_ber_monitor
//  Description : Bit-error-rate monitor for the LVDS loopback link. Clears
//                the link counters, waits for the link pipeline to settle,
//                then runs back-to-back measurement windows of 2^WIN_LOG2
//                CLKF cycles. Each window reports saturating error and
//                received-word deltas plus a debounced LOCKED flag.
//  Options     : `define LVDS_BER_MAXWIN_EN adds MAX_WIN_ERR, the running
//                maximum of WIN_ERR since the last (re)start.
//  Revision    : 1.0 - initial release
// ============================================================================
module lvds_ber_monitor #(
    parameter int WIN_LOG2 = 16,
    parameter int ERR_TH   = 0,
    parameter int GOOD_WIN = 4
) (
    input  logic        RSTXF,
    input  logic        CLKF,
    input  logic        START,
    input  logic        STOP,
    input  logic [63:0] ERR_CNT,
    input  logic [57:0] RECV_CNT,
    output logic        CLR,
    output logic        BUSY,
    output logic        WIN_VALID,
    output logic [31:0] WIN_ERR,
    output logic [31:0] WIN_RECV,
    output logic        LOCKED
`ifdef LVDS_BER_MAXWIN_EN
    ,
    output logic [31:0] MAX_WIN_ERR
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0]          CLEAR_LAST  = 4'd3;   // 4 CLEAR cycles
    localparam logic [3:0]          SETTLE_LAST = 4'd15;  // 16 SETTLE cycles
    localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;     // 2^WIN_LOG2 - 1
    localparam logic [31:0]         ERR_TH_W    = ERR_TH[31:0];
    localparam logic [7:0]          GOOD_WIN_W  = GOOD_WIN[7:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_SAMPLE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          phase_cnt_q, phase_cnt_d;   // CLEAR / SETTLE timing
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;       // MEASURE timing

    // Datapath registers
    logic [63:0] prev_err_q,  prev_err_d;
    logic [57:0] prev_recv_q, prev_recv_d;
    logic [63:0] d_err_q,     d_err_d;
    logic [57:0] d_recv_q,    d_recv_d;
    logic [31:0] win_err_q,   win_err_d;
    logic [31:0] win_recv_q,  win_recv_d;
    logic        win_valid_q, win_valid_d;
    logic [7:0]  good_cnt_q,  good_cnt_d;
    logic        locked_q,    locked_d;
    logic        clr_q,       clr_d;
    logic        busy_q,      busy_d;
`ifdef LVDS_BER_MAXWIN_EN
    logic [31:0] max_err_q,   max_err_d;
`endif

    // Control events
    logic        w_start;      // START not overridden by STOP: (re)enter CLEAR
    logic        w_snap_first; // last SETTLE cycle: take the first snapshot
    logic        w_compute;    // last MEASURE cycle: form the window deltas
    logic        w_sample;     // SAMPLE exit: publish results, reload snapshot
    logic [31:0] w_sat_err;
    logic [31:0] w_sat_recv;
    logic        w_good;

    assign w_start      = START & ~STOP;
    assign w_snap_first = (state_q == S_SETTLE)  && (state_d == S_MEASURE);
    assign w_compute    = (state_q == S_MEASURE) && (state_d == S_SAMPLE);
    assign w_sample     = (state_q == S_SAMPLE)  && (state_d == S_MEASURE);

    // Deltas are registered one cycle before publication, so the wide
    // subtractions and the saturation/compare logic sit in separate cycles.
    assign w_sat_err  = (d_err_q[63:32]  != 32'd0) ? 32'hFFFF_FFFF : d_err_q[31:0];
    assign w_sat_recv = (d_recv_q[57:32] != 26'd0) ? 32'hFFFF_FFFF : d_recv_q[31:0];
    assign w_good     = (w_sat_err <= ERR_TH_W) && (w_sat_recv != 32'd0);

    // ------------------------------------------------------------------------
    // FSM: state and phase counters
    // ------------------------------------------------------------------------

    // State register with asynchronous active-low reset
    always_ff @(posedge CLKF or negedge RSTXF) begin
        if (!RSTXF) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= 4'd0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    // Next-state logic; STOP beats START, and START restarts from any state
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        win_cnt_d   = win_cnt_q;
        if (STOP) begin
            state_d     = S_IDLE;
            phase_cnt_d = 4'd0;
            win_cnt_d   = '0;
        end else if (START) begin
            state_d     = S_CLEAR;
            phase_cnt_d = 4'd0;
            win_cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_CLEAR: begin
                    if (phase_cnt_q == CLEAR_LAST) begin
                        state_d     = S_SETTLE;
                        phase_cnt_d = 4'd0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 4'd1;
                    end
                end
                S_SETTLE: begin
                    if (phase_cnt_q == SETTLE_LAST) begin
                        state_d     = S_MEASURE;
                        phase_cnt_d = 4'd0;
                        win_cnt_d   = '0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 4'd1;
                    end
                end
                S_MEASURE: begin
                    if (win_cnt_q == WIN_LAST) begin
                        state_d   = S_SAMPLE;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    state_d   = S_MEASURE;
                    win_cnt_d = '0;
                end
                default: begin
                    state_d     = S_IDLE;
                    phase_cnt_d = 4'd0;
                    win_cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Snapshot, delta, result and lock next-state computation
    always_comb begin
        prev_err_d  = prev_err_q;
        prev_recv_d = prev_recv_q;
        d_err_d     = d_err_q;
        d_recv_d    = d_recv_q;
        win_err_d   = win_err_q;
        win_recv_d  = win_recv_q;
        good_cnt_d  = good_cnt_q;
        locked_d    = locked_q;
        win_valid_d = w_sample;
        clr_d       = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
`ifdef LVDS_BER_MAXWIN_EN
        max_err_d   = max_err_q;
`endif

        // The window spans exactly the MEASURE cycles: the snapshot is taken
        // entering MEASURE and the counters are read leaving it. Modular
        // subtraction absorbs any wrap of the cumulative link counters.
        if (w_snap_first || w_sample) begin
            prev_err_d  = ERR_CNT;
            prev_recv_d = RECV_CNT;
        end
        if (w_compute) begin
            d_err_d  = ERR_CNT  - prev_err_q;
            d_recv_d = RECV_CNT - prev_recv_q;
        end

        if (w_sample) begin
            win_err_d  = w_sat_err;
            win_recv_d = w_sat_recv;
            if (w_good) begin
                good_cnt_d = (good_cnt_q >= GOOD_WIN_W) ? GOOD_WIN_W
                                                        : good_cnt_q + 8'd1;
            end else begin
                good_cnt_d = 8'd0;
            end
            locked_d = (good_cnt_d == GOOD_WIN_W);
`ifdef LVDS_BER_MAXWIN_EN
            if (w_sat_err > max_err_q) begin
                max_err_d = w_sat_err;
            end
`endif
        end

        // A stop or a restart discards the lock history
        if (STOP || START) begin
            good_cnt_d = 8'd0;
            locked_d   = 1'b0;
        end
`ifdef LVDS_BER_MAXWIN_EN
        if (w_start) begin
            max_err_d = 32'd0;
        end
`endif
    end

    // Datapath registers with asynchronous active-low reset
    always_ff @(posedge CLKF or negedge RSTXF) begin
        if (!RSTXF) begin
            prev_err_q  <= 64'd0;
            prev_recv_q <= 58'd0;
            d_err_q     <= 64'd0;
            d_recv_q    <= 58'd0;
            win_err_q   <= 32'd0;
            win_recv_q  <= 32'd0;
            win_valid_q <= 1'b0;
            good_cnt_q  <= 8'd0;
            locked_q    <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LVDS_BER_MAXWIN_EN
            max_err_q   <= 32'd0;
`endif
        end else begin
            prev_err_q  <= prev_err_d;
            prev_recv_q <= prev_recv_d;
            d_err_q     <= d_err_d;
            d_recv_q    <= d_recv_d;
            win_err_q   <= win_err_d;
            win_recv_q  <= win_recv_d;
            win_valid_q <= win_valid_d;
            good_cnt_q  <= good_cnt_d;
            locked_q    <= locked_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
`ifdef LVDS_BER_MAXWIN_EN
            max_err_q   <= max_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign CLR       = clr_q;
    assign BUSY      = busy_q;
    assign WIN_VALID = win_valid_q;
    assign WIN_ERR   = win_err_q;
    assign WIN_RECV  = win_recv_q;
    assign LOCKED    = locked_q;
`ifdef LVDS_BER_MAXWIN_EN
    assign MAX_WIN_ERR = max_err_q;
`endif

endmodule
`default_nettype wire

// File: doc/lvds_ber_monitor.md
Name: lvds_ber_monitor

Overview:
- Sits directly downstream of the LVDS loopback link top and consumes its cumulative ERR_CNT/RECV_CNT.
- Drives the link's CLR input and runs a fixed-length measurement window.
- Per window, reports the error and received-word deltas plus a debounced LOCKED flag for the bring-up sequencer and register block.
- Runs entirely in the CLKF domain.

Parameters:
- WIN_LOG2, 16: window length is 2^WIN_LOG2 CLKF cycles (legal range 4..30).
- ERR_TH, 0: maximum WIN_ERR for a window to count as good.
- GOOD_WIN, 4: consecutive good windows needed to assert LOCKED (legal range 1..255).

Ports:
- RSTXF  input  1  reset; asynchronous, active-low.
- CLKF  input  1  clock.
- START  input  1  level-sampled; starts or restarts a measurement run.
- STOP  input  1  level-sampled; ends the run and returns to IDLE.
- ERR_CNT  input  64  cumulative error count from the link.
- RECV_CNT  input  58  cumulative received-word count from the link.
- CLR  output  1  clear to the link counters (registered).
- BUSY  output  1  high in any state except IDLE.
- WIN_VALID  output  1  one-cycle pulse; WIN_ERR/WIN_RECV are updated.
- WIN_ERR  output  32  error delta of the last window, saturating.
- WIN_RECV  output  32  received-word delta of the last window, saturating.
- LOCKED  output  1  GOOD_WIN consecutive good windows observed.

Behaviour:
- Reset values: all outputs 0; state IDLE; snapshots, window counter and good counter 0.
- FSM states: IDLE, CLEAR, SETTLE, MEASURE, SAMPLE.
- IDLE -> CLEAR on START.
- CLEAR: exactly 4 cycles, CLR=1 throughout; then SETTLE.
- SETTLE: 16 cycles, which flushes the link pipeline after the clear.
  - On the last SETTLE cycle: capture ERR_CNT/RECV_CNT into snapshot registers (prev_err, prev_recv).
  - Then MEASURE.
- MEASURE: window counter runs 0..2^WIN_LOG2-1; at terminal count go to SAMPLE.
- SAMPLE: one cycle, then MEASURE again with the window counter restarted at 0.
  - d_err = (ERR_CNT - prev_err) mod 2^64.
  - d_recv = (RECV_CNT - prev_recv) mod 2^58. The wrap of a cumulative counter is therefore handled with no special case.
  - WIN_ERR = d_err if d_err < 2^32, else 32'hFFFFFFFF. WIN_RECV uses the same saturation rule on d_recv.
  - Snapshots reload with the current ERR_CNT/RECV_CNT.
  - WIN_ERR, WIN_RECV, WIN_VALID and LOCKED are registered at the SAMPLE exit edge, so WIN_VALID is high on the first cycle after SAMPLE.
- Good window: WIN_ERR <= ERR_TH and WIN_RECV != 0.
  - good_cnt (8 bits) increments on a good window, saturating at GOOD_WIN.
  - Any bad window clears good_cnt and drops LOCKED on the same WIN_VALID edge.
  - LOCKED = 1 when good_cnt reaches GOOD_WIN.
- Timing from START sampled at edge E0: CLR high E0+1..E0+4; first WIN_VALID at E0+21+2^WIN_LOG2+1.
- START in any non-IDLE state restarts the run: go to CLEAR, clear good_cnt and LOCKED. WIN_ERR/WIN_RECV hold their last values.
- STOP in any non-IDLE state: go to IDLE next edge; CLR=0, LOCKED=0, no WIN_VALID. STOP in IDLE is ignored.
- START and STOP asserted in the same cycle: STOP wins.
- Asynchronous reset asserted mid-run: everything returns to the reset values immediately, with no CLR pulse.
- BUSY is registered and equals (next state != IDLE).

Optional Feature:
- Macro LVDS_BER_MAXWIN_EN.
- When defined:
  - Adds output MAX_WIN_ERR[31:0], reset 0.
  - At each WIN_VALID update it takes max(MAX_WIN_ERR, new WIN_ERR).
  - It is cleared to 0 on entry to CLEAR.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- WIN_LOG2=4: reset, START pulse at E0 -> CLR=1 exactly on E0+1..E0+4; BUSY=1 from E0+1; first WIN_VALID at E0+38.
- WIN_LOG2=4, GOOD_WIN=4, ERR_TH=0, ERR_CNT constant, RECV_CNT +1/cycle -> every WIN_RECV=16 and WIN_ERR=0; LOCKED rises with the 4th WIN_VALID.
- While LOCKED, ERR_CNT jumps by 3 within one window -> that window reports WIN_ERR=3; LOCKED falls on the same WIN_VALID; it re-asserts 4 good windows later.
- Snapshot 64'hFFFF_FFFF_FFFF_FFFE, then ERR_CNT wraps to 64'h5 -> WIN_ERR=7.
  - Separately, a delta of 2^33 -> WIN_ERR=32'hFFFFFFFF.
- STOP mid-MEASURE -> IDLE next cycle, BUSY=0, LOCKED=0, no further WIN_VALID.
  - START+STOP in the same cycle -> stays IDLE.
  - RSTXF low mid-CLEAR -> CLR=0 immediately.
- With LVDS_BER_MAXWIN_EN: window errors 2,9,4 -> MAX_WIN_ERR reads 2,9,9; a new START clears it to 0.
